mmc1_cfg_sequencer: RTL

Serial configuration sequencer for the MMC1 mapper core. It accepts whole-register write requests from two requesters, such as a boot/menu loader and a debug port. It arbitrates between them round-robin and replays each request as the five single-bit serial writes the MMC1 load shift register expects. Writes are spaced so none lands on back-to-back cycles. It sits between the on-cartridge configuration masters and the mapper's CPU-side write port.

---
 rtl/mmc1_pkg.sv | 25 ++
 rtl/mmc1_rr_arbiter.sv | 27 ++
 rtl/mmc1_cfg_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mmc1_pkg.sv
// Shared types and constants for the MMC1 serial configuration sequencer.
// Optional pre-reset write slot is selected with `define MMC1_SEQ_PRERESET_EN.
package mmc1_pkg;

  localparam logic [1:0] REG_CTRL = 2'b00;
  localparam logic [1:0] REG_CHR0 = 2'b01;
  localparam logic [1:0] REG_CHR1 = 2'b10;
  localparam logic [1:0] REG_PRG  = 2'b11;

`ifdef MMC1_SEQ_PRERESET_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PRE = 2'd1, ST_SHIFT = 2'd2, ST_GAPW = 2'd3} state_t;
  localparam int N_WRITES = 6;
  localparam int PRE_OFS  = 1;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd2, ST_GAPW = 2'd3} state_t;
  localparam int N_WRITES = 5;
  localparam int PRE_OFS  = 0;
`endif

  typedef struct packed {
    logic [1:0] sel;
    logic [4:0] data;
  } req_t;

endpackage

// File: rtl/mmc1_rr_arbiter.sv
// Two-way round-robin arbiter: combinational grant, last-grant pointer
// advanced only when the grant is actually taken.
module mmc1_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // prio_b=1: B wins a tie. Cleared on reset so A goes first.
  logic prio_b;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio_b ? 2'b10 : 2'b01;
  end

  assign gnt_idx = gnt[1];

  always_ff @(posedge clk) begin
    if (rst)       prio_b <= 1'b0;
    else if (take) prio_b <= ~gnt_idx;
  end

endmodule

// File: rtl/mmc1_cfg_sequencer.sv
// Replays whole-register requests from two masters as spaced MMC1 serial writes.
// `define MMC1_SEQ_PRERESET_EN adds a shift-register reset write before the data bits.
module mmc1_cfg_sequencer
  import mmc1_pkg::*;
#(
  parameter int GAP = 1
) (
  input  logic       CPU_M2,
  input  logic       RST,
  input  logic       REQ_A_VALID,
  output logic       REQ_A_READY,
  input  logic [1:0] REQ_A_SEL,
  input  logic [4:0] REQ_A_DATA,
  input  logic       REQ_B_VALID,
  output logic       REQ_B_READY,
  input  logic [1:0] REQ_B_SEL,
  input  logic [4:0] REQ_B_DATA,
  output logic       WR_STB,
  output logic       WR_A14,
  output logic       WR_A13,
  output logic       WR_D0,
  output logic       WR_D7,
  output logic       BUSY,
  output logic       GRANT,
  output logic       DONE
);

  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  if (GAP < 1) begin : g_bad_gap
    $error("mmc1_cfg_sequencer: GAP must be at least 1");
  end

  state_t        state, state_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [GW-1:0] gap_cnt, gap_cnt_nx;
  req_t          cur;
  logic [1:0]    gnt;
  logic          gnt_idx, idle, take;
  logic [2:0]    k;

  assign idle = (state == ST_IDLE);
  assign take = idle & ~RST & (REQ_A_VALID | REQ_B_VALID);

  mmc1_rr_arbiter u_arb (
    .clk     (CPU_M2),
    .rst     (RST),
    .req     ({REQ_B_VALID, REQ_A_VALID}),
    .take    (take),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign REQ_A_READY = idle & ~RST & gnt[0];
  assign REQ_B_READY = idle & ~RST & gnt[1];
  assign BUSY        = ~idle;

  always_ff @(posedge CPU_M2) begin
    if (RST) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
      gap_cnt <= '0;
      cur     <= '0;
      GRANT   <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      gap_cnt <= gap_cnt_nx;
      if (take) begin
        cur   <= gnt_idx ? {REQ_B_SEL, REQ_B_DATA} : {REQ_A_SEL, REQ_A_DATA};
        GRANT <= gnt_idx;
      end
    end
  end

  // bit_cnt counts every write of the transaction, including the optional PRE slot.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (take) begin
          bit_cnt_nx = 3'd0;
`ifdef MMC1_SEQ_PRERESET_EN
          state_nx   = ST_PRE;
`else
          state_nx   = ST_SHIFT;
`endif
        end
      end
`ifdef MMC1_SEQ_PRERESET_EN
      ST_PRE: begin
        state_nx   = ST_GAPW;
        gap_cnt_nx = '0;
      end
`endif
      ST_SHIFT: begin
        state_nx   = ST_GAPW;
        gap_cnt_nx = '0;
      end
      ST_GAPW: begin
        if (gap_cnt == GAP_LAST) begin
          if (bit_cnt == 3'(N_WRITES - 1)) begin
            state_nx = ST_IDLE;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
            state_nx   = ST_SHIFT;
          end
        end else begin
          gap_cnt_nx = gap_cnt + GW'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign k = bit_cnt - 3'(PRE_OFS);

  always_comb begin
    WR_STB = 1'b0;
    WR_A14 = 1'b0;
    WR_A13 = 1'b0;
    WR_D0  = 1'b0;
    WR_D7  = 1'b0;
    DONE   = 1'b0;
    case (state)
`ifdef MMC1_SEQ_PRERESET_EN
      ST_PRE: begin
        WR_STB           = 1'b1;
        {WR_A14, WR_A13} = cur.sel;
        WR_D7            = 1'b1;
      end
`endif
      ST_SHIFT: begin
        WR_STB           = 1'b1;
        {WR_A14, WR_A13} = cur.sel;
        WR_D0            = cur.data[k];
        DONE             = (k == 3'd4);
      end
      default: ;
    endcase
  end

endmodule
